clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 103 ++++++++++
 tb/tb_clk_div_prog.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : N_CH independent programmable clock dividers. Each channel
//               has a shadow configuration that is swapped in only on a
//               period boundary, so every output period is built entirely
//               from one (period, high) pair.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
  parameter int N_CH          = 2,
  parameter int CNT_W         = 14,
  parameter int DEF_PERIOD_M1 = 9999,
  parameter int DEF_HIGH      = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_period_m1,
  input  logic [CNT_W-1:0] wr_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  localparam logic [CNT_W-1:0] C_DEF_PER  = CNT_W'(DEF_PERIOD_M1);
  localparam logic [CNT_W-1:0] C_DEF_HIGH = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_m1;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_sh_per_m1;
    logic [CNT_W-1:0] r_sh_high;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_wr_hit;
    logic             w_wrap;
    logic             w_apply;
    logic [CNT_W-1:0] w_per_eff;
    logic [CNT_W-1:0] w_high_eff;
    logic [CNT_W-1:0] w_cnt_next;

    // Channel indices beyond N_CH never match, so such writes fall away.
    assign w_wr_hit   = wr_en && (wr_ch == 3'(i));
    assign w_wrap     = (r_cnt == r_per_m1);
    // Shadow is swapped in at a wrap, or on any edge while the channel idles.
    assign w_apply    = r_pending && (w_wrap || !en[i]);
    // The period that starts on the swap edge must already use the new
    // values, otherwise its first cycle would be shaped by the old high.
    assign w_per_eff  = w_apply ? r_sh_per_m1 : r_per_m1;
    assign w_high_eff = w_apply ? r_sh_high   : r_high;
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + C_ONE);

    // Counter, configuration swap and registered outputs for one channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt       <= C_DEF_PER;
        r_per_m1    <= C_DEF_PER;
        r_high      <= C_DEF_HIGH;
        r_sh_per_m1 <= C_DEF_PER;
        r_sh_high   <= C_DEF_HIGH;
        r_pending   <= 1'b0;
        r_clk_out   <= 1'b0;
        r_tick      <= 1'b0;
      end else begin
        if (w_apply) begin
          r_per_m1 <= r_sh_per_m1;
          r_high   <= r_sh_high;
        end
        // A write on the swap edge re-arms pending for the following wrap.
        if (w_wr_hit) begin
          r_sh_per_m1 <= wr_period_m1;
          r_sh_high   <= wr_high;
          r_pending   <= 1'b1;
        end else if (w_apply) begin
          r_pending <= 1'b0;
        end
        if (en[i]) begin
          r_cnt     <= w_cnt_next;
          r_clk_out <= (w_cnt_next < w_high_eff);
          r_tick    <= w_wrap;
        end else begin
          // Parking at the period end makes the first enabled edge a wrap.
          r_cnt     <= w_per_eff;
          r_clk_out <= 1'b0;
          r_tick    <= 1'b0;
        end
      end
    end

    assign clk_out[i] = r_clk_out;
    assign tick[i]    = r_tick;
    assign pending[i] = r_pending;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Self-checking bench for clk_div_prog: vector table, corner
//               sequences and randomized traffic against a period-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

  localparam int N_CH     = 2;
  localparam int CNT_W    = 14;
  localparam int DEF_PER  = 9999;
  localparam int DEF_HIGH = 5000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_CH-1:0]  en = '0;
  logic             wr_en = 1'b0;
  logic [2:0]       wr_ch = '0;
  logic [CNT_W-1:0] wr_period_m1 = '0;
  logic [CNT_W-1:0] wr_high = '0;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD_M1(DEF_PER), .DEF_HIGH(DEF_HIGH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period_m1(wr_period_m1), .wr_high(wr_high),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model (period-position view) -------------
  bit model_on = 1'b0;
  int m_per[N_CH], m_high[N_CH], m_sh_per[N_CH], m_sh_high[N_CH], m_pos[N_CH];
  bit m_pend[N_CH], m_fresh[N_CH], m_clk[N_CH], m_tick[N_CH];

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_per[c] = DEF_PER;  m_high[c] = DEF_HIGH;
      m_sh_per[c] = DEF_PER; m_sh_high[c] = DEF_HIGH;
      m_pend[c] = 0; m_fresh[c] = 1; m_pos[c] = 0;
      m_clk[c] = 0; m_tick[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < N_CH; c++) begin
      if (en[c]) begin
        if (m_fresh[c] || m_pos[c] == m_per[c]) begin
          // New output period: latest complete configuration takes over.
          if (m_pend[c]) begin
            m_per[c] = m_sh_per[c]; m_high[c] = m_sh_high[c]; m_pend[c] = 0;
          end
          m_pos[c] = 0;
          m_fresh[c] = 0;
        end else begin
          m_pos[c]++;
        end
        m_clk[c]  = (m_pos[c] < m_high[c]);
        m_tick[c] = (m_pos[c] == 0);
      end else begin
        if (m_pend[c]) begin
          m_per[c] = m_sh_per[c]; m_high[c] = m_sh_high[c]; m_pend[c] = 0;
        end
        m_fresh[c] = 1;
        m_clk[c] = 0; m_tick[c] = 0;
      end
      if (wr_en && int'(wr_ch) == c) begin
        m_sh_per[c] = int'(wr_period_m1); m_sh_high[c] = int'(wr_high);
        m_pend[c] = 1;
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (model_on && rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    rst_n = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0;
    wr_period_m1 = '0; wr_high = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Program channel 0 while idle, leaving it enabled with the new settings.
  task automatic cfg_ch0(input int per, input int hi);
    en = '0; wr_en = 1'b1; wr_ch = 3'd0;
    wr_period_m1 = CNT_W'(per); wr_high = CNT_W'(hi);
    cyc();
    wr_en = 1'b0;
    cyc();
    check("cfg_pending_cleared", int'(pending[0]), 0);
    en = 2'b01;
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    logic [1:0] en;
    logic       wr;
    int         ch;
    int         per;
    int         hi;
    logic [1:0] e_clk;
    logic [1:0] e_tick;
    logic [1:0] e_pend;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic [1:0] e, logic w, int ch, int per, int hi,
                              logic [1:0] ec, logic [1:0] et, logic [1:0] ep);
    vec_t v;
    v.en = e; v.wr = w; v.ch = ch; v.per = per; v.hi = hi;
    v.e_clk = ec; v.e_tick = et; v.e_pend = ep;
    return v;
  endfunction

  initial begin
    int tcount[N_CH];
    int hcount[N_CH];
    int exp_t;

    // Idle write, then 1100 pattern, double write (last wins -> 111000),
    // ignored write to ch5, then a 3-cycle disable of channel 0.
    tbl[0]  = mk(2'b00, 1, 0, 3, 2, 2'b00, 2'b00, 2'b01);
    tbl[1]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[2]  = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    tbl[3]  = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    tbl[4]  = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[5]  = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[6]  = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    tbl[7]  = mk(2'b01, 1, 0, 4, 1, 2'b01, 2'b00, 2'b01);
    tbl[8]  = mk(2'b01, 1, 0, 5, 3, 2'b00, 2'b00, 2'b01);
    tbl[9]  = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01);
    tbl[10] = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    tbl[11] = mk(2'b01, 1, 5, 1, 1, 2'b01, 2'b00, 2'b00);
    tbl[12] = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    tbl[13] = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[14] = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[15] = mk(2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[16] = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    tbl[17] = mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[18] = mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[19] = mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[20] = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00);
    tbl[21] = mk(2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);

    // ---- reset state ----
    rst_n = 1'b0;
    #12;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_pending", int'(pending), 0);
    do_reset();

    // ---- table ----
    for (int r = 0; r < 22; r++) begin
      en = tbl[r].en; wr_en = tbl[r].wr; wr_ch = 3'(tbl[r].ch);
      wr_period_m1 = CNT_W'(tbl[r].per); wr_high = CNT_W'(tbl[r].hi);
      cyc();
      check($sformatf("tbl%0d_clk_out", r), int'(clk_out), int'(tbl[r].e_clk));
      check($sformatf("tbl%0d_tick", r), int'(tick), int'(tbl[r].e_tick));
      check($sformatf("tbl%0d_pending", r), int'(pending), int'(tbl[r].e_pend));
    end
    wr_en = 1'b0;

    // ---- boundary settings on channel 0 ----
    begin
      int bper[4] = '{3, 3, 0, 0};
      int bhi[4]  = '{0, 7, 1, 0};
      for (int b = 0; b < 4; b++) begin
        cfg_ch0(bper[b], bhi[b]);
        for (int k = 0; k < 8; k++) begin
          cyc();
          exp_t = (bper[b] == 0) ? 1 : ((k % (bper[b] + 1)) == 0);
          check($sformatf("bnd%0d_clk_k%0d", b, k), int'(clk_out[0]),
                (bhi[b] == 0) ? 0 : ((bhi[b] > bper[b]) ? 1 : (k % (bper[b] + 1) < bhi[b])));
          check($sformatf("bnd%0d_tick_k%0d", b, k), int'(tick[0]), exp_t);
        end
      end
    end

    // ---- default timing: two full 10000-cycle periods ----
    do_reset();
    en = 2'b11;
    for (int c = 0; c < N_CH; c++) begin tcount[c] = 0; hcount[c] = 0; end
    for (int k = 0; k < 2 * (DEF_PER + 1); k++) begin
      cyc();
      if (k == 0) begin
        check("def_first_tick", int'(tick), 3);
        check("def_first_clk", int'(clk_out), 3);
      end
      if (k == DEF_HIGH - 1) check("def_last_high", int'(clk_out), 3);
      if (k == DEF_HIGH)     check("def_first_low", int'(clk_out), 0);
      for (int c = 0; c < N_CH; c++) begin
        tcount[c] += int'(tick[c]);
        hcount[c] += int'(clk_out[c]);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("def_ticks_ch%0d", c), tcount[c], 2);
      check($sformatf("def_highs_ch%0d", c), hcount[c], 2 * DEF_HIGH);
    end

    // ---- async reset mid-high-phase with a pending write ----
    repeat (100) cyc();
    wr_en = 1'b1; wr_ch = 3'd0; wr_period_m1 = CNT_W'(3); wr_high = CNT_W'(2);
    cyc();
    wr_en = 1'b0;
    check("rst_pre_pending", int'(pending), 1);
    check("rst_pre_clk", int'(clk_out), 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_clk", int'(clk_out), 0);
    check("rst_async_tick", int'(tick), 0);
    check("rst_async_pending", int'(pending), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    check("rst_resume_tick", int'(tick), 3);
    check("rst_resume_clk", int'(clk_out), 3);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("rst_resume_high", int'(clk_out), 3);
      check("rst_resume_notick", int'(tick), 0);
      check("rst_resume_pending", int'(pending), 0);
    end

    // ---- randomized traffic against the model ----
    do_reset();
    model_on = 1'b1;
    for (int k = 0; k < 4; k++) begin
      en = '0; wr_en = 1'b1; wr_ch = 3'(k % 2);
      wr_period_m1 = CNT_W'($urandom_range(0, 7));
      wr_high = CNT_W'($urandom_range(0, 9));
      cyc();
    end
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N_CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7))
                                          : 3'($urandom_range(0, 1));
      wr_period_m1 = CNT_W'($urandom_range(0, 7));
      wr_high = CNT_W'($urandom_range(0, 9));
      cyc();
      for (int c = 0; c < N_CH; c++) begin
        check($sformatf("rnd_clk_ch%0d", c), int'(clk_out[c]), int'(m_clk[c]));
        check($sformatf("rnd_tick_ch%0d", c), int'(tick[c]), int'(m_tick[c]));
        check($sformatf("rnd_pend_ch%0d", c), int'(pending[c]), int'(m_pend[c]));
      end
    end
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
